// File: rtl/rr_mux_arbiter_4_if.sv
// rr_mux_arbiter_4_if: bundle of requester, mux-data and downstream handshake signals
//   req       4   pending-word flags, one per requester
//   d0..d3    W   requester data words
//   out_ready 1   consumer accepts y when out_valid=1
//   gnt       4   one-hot combinational grant
//   sel       2   index of requester whose word is in y
//   y         W   registered output word
//   out_valid 1   y holds an unconsumed word
//   master: producers/consumer side; slave: arbiter side
interface rr_mux_arbiter_4_if #(
    parameter int W = 4
);
    logic [3:0]   req;
    logic [W-1:0] d0;
    logic [W-1:0] d1;
    logic [W-1:0] d2;
    logic [W-1:0] d3;
    logic         out_ready;
    logic [3:0]   gnt;
    logic [1:0]   sel;
    logic [W-1:0] y;
    logic         out_valid;
    modport master (
        output req, d0, d1, d2, d3, out_ready,
        input  gnt, sel, y, out_valid
    );
    modport slave (
        input  req, d0, d1, d2, d3, out_ready,
        output gnt, sel, y, out_valid
    );
endinterface

// File: rtl/rr_mux_arbiter_4.sv
// rr_mux_arbiter_4: round-robin arbiter driving a shared 4:1 mux into a valid/ready output register
//   clk    clock, rising edge
//   rst_n  asynchronous active-low reset
//   bus    rr_mux_arbiter_4_if.slave (req, d0..d3, out_ready in; gnt, sel, y, out_valid out)
//   ARB_FIXED_PRIO_EN defined: priority pointer frozen at PTR_INIT (fixed priority)
module rr_mux_arbiter_4 #(
    parameter int         W        = 4,
    parameter logic [1:0] PTR_INIT = 2'd0
) (
    input logic              clk,
    input logic              rst_n,
    rr_mux_arbiter_4_if.slave bus
);
    typedef enum logic {IDLE, FULL} state_t;
    state_t       state_q, state_d;
    logic [1:0]   ptr_q, ptr_d;
    logic [1:0]   sel_q, sel_d;
    logic [W-1:0] y_q, y_d;
    logic [1:0]   win;
    logic         take;
    logic [W-1:0] d_arr [4];
    assign d_arr[0] = bus.d0;
    assign d_arr[1] = bus.d1;
    assign d_arr[2] = bus.d2;
    assign d_arr[3] = bus.d3;
    // Scan from furthest to nearest so the first pending index after ptr wins.
    always_comb begin
        win = ptr_q;
        for (int k = 3; k >= 0; k--)
            if (bus.req[ptr_q + 2'(k)]) win = ptr_q + 2'(k);
    end
    // rst_n gating keeps gnt low during reset even though state already reads IDLE.
    assign take = rst_n && (bus.req != 4'b0) && (state_q == IDLE || bus.out_ready);
    assign bus.gnt = take ? (4'b0001 << win) : 4'b0000;
    always_comb begin
        state_d = state_q;
        ptr_d   = ptr_q;
        sel_d   = sel_q;
        y_d     = y_q;
        if (take) begin
            state_d = FULL;
            sel_d   = win;
            y_d     = d_arr[win];
`ifdef ARB_FIXED_PRIO_EN
            ptr_d   = ptr_q;
`else
            ptr_d   = win + 2'd1;
`endif
        end else if (state_q == FULL && bus.out_ready) begin
            state_d = IDLE;
        end
    end
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            ptr_q   <= PTR_INIT;
            sel_q   <= 2'd0;
            y_q     <= '0;
        end else begin
            state_q <= state_d;
            ptr_q   <= ptr_d;
            sel_q   <= sel_d;
            y_q     <= y_d;
        end
    end
    assign bus.sel       = sel_q;
    assign bus.y         = y_q;
    assign bus.out_valid = (state_q == FULL);
endmodule

// File: tb/tb_rr_mux_arbiter_4.sv
// tb_rr_mux_arbiter_4: directed self-checking bench for rr_mux_arbiter_4 (honours ARB_FIXED_PRIO_EN)
module tb_rr_mux_arbiter_4;
    localparam int W = 4;
    logic clk = 1'b0;
    logic rst_n;
    int   checks = 0;
    int   errors = 0;
    rr_mux_arbiter_4_if #(.W(W)) bus ();
    rr_mux_arbiter_4 #(.W(W), .PTR_INIT(2'd0)) dut (
        .clk  (clk),
        .rst_n(rst_n),
        .bus  (bus)
    );
    always #5 clk = ~clk;
`ifdef ARB_FIXED_PRIO_EN
    localparam logic [3:0] G2 [5] = '{4'b0001, 4'b0001, 4'b0001, 4'b0001, 4'b0001};
    localparam logic [3:0] Y2 [5] = '{4'ha, 4'ha, 4'ha, 4'ha, 4'ha};
    localparam logic [1:0] S2 [5] = '{2'd0, 2'd0, 2'd0, 2'd0, 2'd0};
    localparam logic [3:0] G3 [3] = '{4'b0001, 4'b0001, 4'b0001};
    localparam logic [3:0] Y3 [3] = '{4'ha, 4'ha, 4'ha};
    localparam logic [1:0] S3 [3] = '{2'd0, 2'd0, 2'd0};
`else
    localparam logic [3:0] G2 [5] = '{4'b0001, 4'b0010, 4'b0100, 4'b1000, 4'b0001};
    localparam logic [3:0] Y2 [5] = '{4'ha, 4'hb, 4'hc, 4'hd, 4'ha};
    localparam logic [1:0] S2 [5] = '{2'd0, 2'd1, 2'd2, 2'd3, 2'd0};
    localparam logic [3:0] G3 [3] = '{4'b1000, 4'b0001, 4'b0010};
    localparam logic [3:0] Y3 [3] = '{4'hd, 4'ha, 4'hb};
    localparam logic [1:0] S3 [3] = '{2'd3, 2'd0, 2'd1};
`endif
    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s got %h exp %h", tag, obs, exp);
        end
    endtask
    task automatic tick;
        @(posedge clk);
        #1;
    endtask
    initial begin
        rst_n = 1'b0;
        bus.req = 4'b0;
        bus.out_ready = 1'b0;
        bus.d0 = 4'ha;
        bus.d1 = 4'hb;
        bus.d2 = 4'hc;
        bus.d3 = 4'hd;
        #3;
        check("rst_valid", 32'(bus.out_valid), 32'd0);
        check("rst_y", 32'(bus.y), 32'd0);
        check("rst_sel", 32'(bus.sel), 32'd0);
        bus.req = 4'b1111;
        #1;
        check("rst_gnt", 32'(bus.gnt), 32'd0);
        bus.req = 4'b0;
        tick;
        rst_n = 1'b1;
        // single requester
        bus.req = 4'b0010;
        bus.out_ready = 1'b1;
        #1;
        check("t1_gnt", 32'(bus.gnt), 32'b0010);
        tick;
        bus.req = 4'b0;
        check("t1_y", 32'(bus.y), 32'hb);
        check("t1_sel", 32'(bus.sel), 32'd1);
        check("t1_valid", 32'(bus.out_valid), 32'd1);
        // drain
        #1;
        check("t4_gnt", 32'(bus.gnt), 32'd0);
        tick;
        check("t4_valid", 32'(bus.out_valid), 32'd0);
        check("t4_y", 32'(bus.y), 32'hb);
        // reset pulse between edges to restore ptr
        #2 rst_n = 1'b0;
        #2 rst_n = 1'b1;
        tick;
        // all requesting, round robin with wrap
        bus.req = 4'b1111;
        for (int i = 0; i < 5; i++) begin
            #1;
            check($sformatf("t2_gnt%0d", i), 32'(bus.gnt), 32'(G2[i]));
            tick;
            check($sformatf("t2_y%0d", i), 32'(bus.y), 32'(Y2[i]));
            check($sformatf("t2_sel%0d", i), 32'(bus.sel), 32'(S2[i]));
            check($sformatf("t2_valid%0d", i), 32'(bus.out_valid), 32'd1);
        end
        // load y=c, then back-pressure
        bus.req = 4'b0100;
        #1;
        check("t3_load_gnt", 32'(bus.gnt), 32'b0100);
        tick;
        check("t3_load_y", 32'(bus.y), 32'hc);
        bus.out_ready = 1'b0;
        bus.req = 4'b1011;
        for (int i = 0; i < 3; i++) begin
            #1;
            check($sformatf("t3_bp_gnt%0d", i), 32'(bus.gnt), 32'd0);
            tick;
            check($sformatf("t3_bp_y%0d", i), 32'(bus.y), 32'hc);
            check($sformatf("t3_bp_sel%0d", i), 32'(bus.sel), 32'd2);
            check($sformatf("t3_bp_valid%0d", i), 32'(bus.out_valid), 32'd1);
        end
        bus.out_ready = 1'b1;
        for (int i = 0; i < 3; i++) begin
            #1;
            check($sformatf("t3_gnt%0d", i), 32'(bus.gnt), 32'(G3[i]));
            tick;
            check($sformatf("t3_y%0d", i), 32'(bus.y), 32'(Y3[i]));
            check($sformatf("t3_sel%0d", i), 32'(bus.sel), 32'(S3[i]));
        end
        // async reset mid-stream
        rst_n = 1'b0;
        #1;
        check("t5_valid", 32'(bus.out_valid), 32'd0);
        check("t5_y", 32'(bus.y), 32'd0);
        check("t5_sel", 32'(bus.sel), 32'd0);
        check("t5_gnt", 32'(bus.gnt), 32'd0);
        #2 rst_n = 1'b1;
        bus.req = 4'b1000;
        #1;
        check("t5_post_gnt", 32'(bus.gnt), 32'b1000);
        tick;
        bus.req = 4'b0;
        check("t5_post_y", 32'(bus.y), 32'hd);
        check("t5_post_sel", 32'(bus.sel), 32'd3);
        check("t5_post_valid", 32'(bus.out_valid), 32'd1);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
